// File: rtl/mips_bp_pkg.sv
// Shared types and constants for the MIPS branch recovery slice.
// Imported by branch_recovery_ctrl and sat_counter.
package mips_bp_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for branch and misprediction performance counts.
module sat_counter
  import mips_bp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Registered PC redirect and F/D flush sequencer for decode-stage mispredicts.
// Define BRANCH_PERF_CNT_EN to enable the saturating branch/mispredict counters.
module branch_recovery_ctrl
  import mips_bp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Branch_D,
  input  logic             branch_taken_D,
  input  logic [PC_W-1:0]  PC_D,
  input  logic [PC_W-1:0]  PCBranch_result_D,
  input  logic             Misprediction_for_taken,
  input  logic             Misprediction_for_not_taken,
  input  logic             StallF,
  output logic             redirect_sel,
  output logic [PC_W-1:0]  redirect_PC,
  output logic             FlushD,
  output logic             recovering,
  output logic             proto_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_t r_state;
  state_t w_next;

  logic            w_idle;
  logic            w_accept;
  logic            w_both;
  logic [PC_W-1:0] w_target;

  logic            r_redirect_sel;
  logic            r_flushd;
  logic            r_recovering;
  logic            r_proto_err;
  logic [PC_W-1:0] r_redirect_pc;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & Branch_D &
                    (Misprediction_for_taken | Misprediction_for_not_taken);
  assign w_both   = Misprediction_for_taken & Misprediction_for_not_taken;
  assign w_target = Misprediction_for_not_taken ? PCBranch_result_D
                                                : PC_D + PC_INC;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_accept) w_next = REDIRECT;
      REDIRECT: if (!StallF)  w_next = FLUSH;
      FLUSH:    w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they toggle with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_redirect_sel <= 1'b0;
      r_flushd       <= 1'b0;
      r_recovering   <= 1'b0;
      r_proto_err    <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_state        <= w_next;
      r_redirect_sel <= (w_next == REDIRECT);
      r_flushd       <= (w_next != IDLE);
      r_recovering   <= (w_next != IDLE);
      if (w_accept) begin
        r_redirect_pc <= w_target;
        if (w_both) r_proto_err <= 1'b1;
      end
    end
  end

  assign redirect_sel = r_redirect_sel;
  assign redirect_PC  = r_redirect_pc;
  assign FlushD       = r_flushd;
  assign recovering   = r_recovering;
  assign proto_err    = r_proto_err;

`ifdef BRANCH_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_idle & Branch_D),
    .clear (1'b0),
    .cnt   (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_accept),
    .clear (1'b0),
    .cnt   (mispredict_cnt)
  );
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

  logic w_unused;
  assign w_unused = branch_taken_D;

endmodule

// File: doc/branch_recovery_ctrl.md
# branch_recovery_ctrl

Sequencing controller that sits beside the Branch_Predictor in the MIPS pipeline and turns its decode-stage misprediction flags into a registered, stall-aware PC redirect and fetch/decode flush sequence. It latches the correct-path target, drives the fetch-stage PC mux override and the D-register flush for the two wrong-path slots, and ignores wrong-path branches while recovering. Optional counters record resolved branches and mispredictions.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- Branch_D  in  1  branch instruction present in decode
- branch_taken_D  in  1  actual resolved direction in decode
- PC_D  in  32  PC of the decode-stage branch
- PCBranch_result_D  in  32  computed branch target
- Misprediction_for_taken  in  1  predictor said taken, branch not taken
- Misprediction_for_not_taken  in  1  predictor said not taken, branch taken
- StallF  in  1  fetch stall from hazard unit
- redirect_sel  out  1  overrides the fetch PC mux with redirect_PC
- redirect_PC  out  32  correct-path fetch address
- FlushD  out  1  clears the F/D pipeline register
- recovering  out  1  high in any non-IDLE state
- proto_err  out  1  sticky; both misprediction flags seen together
- branch_cnt  out  CNT_W  resolved-branch count
- mispredict_cnt  out  CNT_W  misprediction count

## Operation
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE: a misprediction is accepted on a rising edge where Branch_D=1 and either misprediction flag is 1.
  - Target latched: PC_D+4 for Misprediction_for_taken, PCBranch_result_D for Misprediction_for_not_taken.
  - Next state: REDIRECT.
- Both flags high: not_taken takes priority (target = PCBranch_result_D) and proto_err sets. proto_err clears only on reset.
- Misprediction flags with Branch_D=0 are ignored.
- REDIRECT: redirect_sel=1, FlushD=1, redirect_PC=latched target.
  - StallF=1: stay in REDIRECT with outputs held.
  - StallF=0: go to FLUSH.
- FLUSH: FlushD=1 and redirect_sel=0, clearing the instruction fetched during the redirect edge. Unconditionally returns to IDLE.
- Inputs are ignored in REDIRECT and FLUSH, because the decode contents are wrong-path. A back-to-back misprediction is only accepted from IDLE.
- Arithmetic: PC_D+4 is 32-bit modulo, so 0xFFFF_FFFC+4 gives 0x0000_0000.
- Outputs are registered; redirect_PC holds its last value in IDLE.
- Reset: async to IDLE. redirect_sel, FlushD, recovering and proto_err are 0; redirect_PC is 0; both counters are 0. Reset mid-recovery abandons the redirect.

## Timing
- Misprediction sampled at edge T gives redirect_sel and FlushD high in cycle T+1, FlushD only in T+2, and IDLE in T+3.
- Each REDIRECT cycle with StallF=1 adds one cycle of extension.
- Minimum spacing between accepted mispredictions is 3 cycles.

## Configuration
- BRANCH_PERF_CNT_EN defined: counters are active.
  - branch_cnt increments on every IDLE edge with Branch_D=1.
  - mispredict_cnt increments on every accepted misprediction.
  - Both saturate at 2^CNT_W-1.
- BRANCH_PERF_CNT_EN undefined: no counter flops; branch_cnt and mispredict_cnt are constant 0.

## Structure
- Shared package mips_bp_pkg holds:
  - the state enum (IDLE, REDIRECT, FLUSH)
  - PC_W=32
  - PC_INC=32'd4
- The only sub-module is sat_counter (parameter W; inputs inc and clear; saturating output). It is instantiated twice under the macro.

## Test plan
- Reset held for 4 cycles, then released: all outputs 0, recovering=0, and the FSM stays in IDLE with Branch_D=0.
- Branch_D=1, Misprediction_for_not_taken=1, PCBranch_result_D=0x0000FFF0:
  - T+1: redirect_sel=1, redirect_PC=0x0000FFF0, FlushD=1.
  - T+2: FlushD=1 only.
  - T+3: IDLE.
- Branch_D=1, Misprediction_for_taken=1, PC_D=0x0000BBC0: redirect_PC=0x0000BBC4. Then PC_D=0xFFFFFFFC gives redirect_PC=0x00000000.
- Misprediction with StallF=1 for 3 cycles: REDIRECT is held for 4 cycles with a stable target, then FLUSH follows. A second Branch_D+misprediction during recovery causes no new redirect and no mispredict_cnt change.
- Both misprediction flags high: target = PCBranch_result_D and proto_err=1. Then an rst_n pulse in the REDIRECT cycle forces all outputs to 0 asynchronously.
- With BRANCH_PERF_CNT_EN and CNT_W=4: 20 correct branches give branch_cnt=15 (saturated). Without the macro both counters read 0.
